time_entry_loader: RTL and testbench
====================================

# time_entry_loader

Keypad-side writer for the MS_Timer load interface. Accepts decimal key presses, shifts them microwave-style into a four-digit BCD MM:SS entry register, normalizes the value on start, then drives the timer's parallel-load and enable inputs. It tracks the run until the timer reports zero and returns to idle on cancel. Sits between the keypad encoder and the MS_Timer counter chain.

## Interface
- MAX_DIGITS, 4, number of digits accepted per entry (1..4); further keys are ignored
- clk  input  1  system clock, all state changes on rising edge
- clear  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe, key_code valid
- key_code  input  4  BCD digit 0..9; codes 10..15 ignored (no state change)
- start_req  input  1  level, sampled each edge; start cooking
- cancel_req  input  1  level, sampled each edge; abort and clear entry
- timer_zero  input  1  high when the MS_Timer reads 00:00
- min_tens, min_units, sec_tens, sec_units  output  4 each  BCD load value to timer
- load_n  output  1  active-low parallel-load strobe to timer counters
- enab_timer  output  1  count enable to timer
- digit_count  output  3  digits accepted in current entry (0..MAX_DIGITS)
- entry_active  output  1  high in ENTRY
- done  output  1  high in DONE

## Operation
- States: IDLE, ENTRY, LOAD, RUN, DONE. Reset state IDLE.
- Reset values: all digits 0, load_n=1, enab_timer=0, digit_count=0, entry_active=0, done=0.
- Accepted key (valid code, digit_count<MAX_DIGITS) shifts: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key_code; digit_count+1. Leading zeros count as digits.
- IDLE: accepted key -> shift, go ENTRY. start_req ignored.
- ENTRY: accepted key -> shift. start_req with nonzero value -> normalize, go LOAD. start_req with value 00:00 -> ignored, stay ENTRY.
- Normalize, applied on the LOAD transition edge: if sec_tens>5, set sec_tens=5 and sec_units=9. Minutes are never altered.
- LOAD: exactly one cycle. load_n=0, digits stable. Then go RUN.
- RUN: enab_timer=1. Keys ignored. timer_zero=1 -> enab_timer=0, go DONE.
- DONE: done=1. Any accepted key -> clear digits, digit_count=0, then shift the key in, go ENTRY. cancel_req -> IDLE.
- cancel_req in any state: digits<=0, digit_count<=0, load_n=1, enab_timer=0, go IDLE.
- Priority per edge: clear > cancel_req > start_req > key_valid. A key arriving in the same cycle as an accepted start is dropped.
- Reset mid-operation (any state): all outputs take reset values immediately (asynchronous), with no load pulse emitted.

## Timing
- Key accepted at edge N: digits and digit_count updated and visible after edge N. entry_active rises after N when leaving IDLE.
- start_req sampled at edge N in ENTRY: load_n=0 from after N to after N+1, with normalized digits valid over the same window.
- enab_timer=1 from after N+1, in the same cycle RUN is entered.
- timer_zero is ignored during LOAD and sampled only in RUN. It is seen at edge M: enab_timer=0 and done=1 after M.
- load_n never stays low more than one cycle. load_n=0 and enab_timer=1 are never asserted together.
- All outputs are registered. No combinational input-to-output paths.

## Test plan
- Reset and entry: assert clear mid-run, release, then keys 1,2,3,0 -> after last key digits 1,2,3,0, digit_count=4, load_n=1, enab_timer=0.
- Overflow: keys 1,2,3,4,5 -> fifth key ignored, digits 1,2,3,4, digit_count=4. Key code 12 -> no change.
- Start and normalize: keys 9,9 then start_req -> load_n low exactly 1 cycle with 0,0,5,9. enab_timer=1 the following cycle. Keys during RUN leave digits unchanged.
- Zero start: key 0 then start_req -> stays ENTRY, no load pulse. Then key 5 and start -> loads 0,0,0,5.
- Completion: in RUN, pulse timer_zero -> enab_timer=0 and done=1 next cycle. Key 7 -> digits 0,0,0,7, digit_count=1, entry_active=1.
- Priorities: start_req with key_valid (code 8) in ENTRY holding 4,2 -> loads 0,0,4,2 and the key is dropped. cancel_req with start_req -> IDLE, all zero, no load pulse. cancel in RUN -> enab_timer=0 next cycle.

Source files
------------

// File: rtl/time_entry_loader.sv
`default_nettype none
// ============================================================================
// Module   : time_entry_loader
// Purpose  : Keypad-driven MM:SS BCD entry, normalize, and load/enable
//            sequencing for the MS_Timer counter chain.
// Revision : 1.0 - initial release
// ============================================================================
module time_entry_loader #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_req,
  input  logic       cancel_req,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       load_n,
  output logic       enab_timer,
  output logic [2:0] digit_count,
  output logic       entry_active,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] C_MAX_DIGITS = 3'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  count_q, count_d;
  logic        load_n_q, load_n_d;
  logic        enab_timer_q, enab_timer_d;
  logic        entry_active_q, entry_active_d;
  logic        done_q, done_d;

  logic        w_key_digit;
  logic        w_key_ok;
  logic        w_nonzero;
  logic [15:0] w_shifted;
  logic [15:0] w_normalized;

  always_comb begin
    w_key_digit  = key_valid && (key_code <= 4'd9);
    w_key_ok     = w_key_digit && (count_q < C_MAX_DIGITS);
    w_nonzero    = |digits_q;
    w_shifted    = {digits_q[11:0], key_code};
    // Seconds tens above 5 means the user typed e.g. "99": clamp to :59.
    w_normalized = (digits_q[7:4] > 4'd5) ? {digits_q[15:8], 4'd5, 4'd9}
                                          : digits_q;
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;

    if (cancel_req) begin
      state_d  = S_IDLE;
      digits_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (w_key_ok) begin
            digits_d = w_shifted;
            count_d  = count_q + 3'd1;
            state_d  = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (start_req && w_nonzero) begin
            digits_d = w_normalized;
            state_d  = S_LOAD;
          end else if (w_key_ok) begin
            digits_d = w_shifted;
            count_d  = count_q + 3'd1;
          end
        end
        S_LOAD: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (timer_zero) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // A fresh entry starts from a cleared register, so count is not gated.
          if (w_key_digit) begin
            digits_d = {12'd0, key_code};
            count_d  = 3'd1;
            state_d  = S_ENTRY;
          end
        end
        default: begin
          state_d  = S_IDLE;
          digits_d = '0;
          count_d  = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they align with it.
    load_n_d       = (state_d != S_LOAD);
    enab_timer_d   = (state_d == S_RUN);
    entry_active_d = (state_d == S_ENTRY);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q        <= S_IDLE;
      digits_q       <= '0;
      count_q        <= '0;
      load_n_q       <= 1'b1;
      enab_timer_q   <= 1'b0;
      entry_active_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      digits_q       <= digits_d;
      count_q        <= count_d;
      load_n_q       <= load_n_d;
      enab_timer_q   <= enab_timer_d;
      entry_active_q <= entry_active_d;
      done_q         <= done_d;
    end
  end

  assign min_tens     = digits_q[15:12];
  assign min_units    = digits_q[11:8];
  assign sec_tens     = digits_q[7:4];
  assign sec_units    = digits_q[3:0];
  assign load_n       = load_n_q;
  assign enab_timer   = enab_timer_q;
  assign digit_count  = count_q;
  assign entry_active = entry_active_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_time_entry_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_entry_loader
// Purpose  : Directed plus randomized bench for time_entry_loader against a
//            decimal-value reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_entry_loader;

  localparam int MAX_DIGITS = 4;
  localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start_req = 1'b0;
  logic       cancel_req = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       load_n, enab_timer, entry_active, done;
  logic [2:0] digit_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: entry held as a plain decimal number MMSS.
  int m_phase = P_IDLE;
  int m_val   = 0;
  int m_cnt   = 0;

  time_entry_loader #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .start_req(start_req), .cancel_req(cancel_req), .timer_zero(timer_zero),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .load_n(load_n), .enab_timer(enab_timer),
    .digit_count(digit_count), .entry_active(entry_active), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
  endtask

  function automatic int bcd_of(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int dut_digits();
    return int'({min_tens, min_units, sec_tens, sec_units});
  endfunction

  task automatic model_edge(input bit kv, input int kc, input bit st,
                            input bit cn, input bit tz);
    bit digit;
    digit = kv && (kc <= 9);
    if (cn) begin
      m_phase = P_IDLE; m_val = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (digit && m_cnt < MAX_DIGITS) begin
                   m_val = (m_val * 10 + kc) % 10000; m_cnt++; m_phase = P_ENTRY;
                 end
        P_ENTRY: if (st && m_val != 0) begin
                   if ((m_val / 10) % 10 > 5) m_val = (m_val / 100) * 100 + 59;
                   m_phase = P_LOAD;
                 end else if (digit && m_cnt < MAX_DIGITS) begin
                   m_val = (m_val * 10 + kc) % 10000; m_cnt++;
                 end
        P_LOAD:  m_phase = P_RUN;
        P_RUN:   if (tz) m_phase = P_DONE;
        default: if (digit) begin
                   m_val = kc; m_cnt = 1; m_phase = P_ENTRY;
                 end
      endcase
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".digits"}, dut_digits(), bcd_of(m_val));
    chk({ctx, ".count"},  int'(digit_count), m_cnt);
    chk({ctx, ".load_n"}, int'(load_n), (m_phase == P_LOAD) ? 0 : 1);
    chk({ctx, ".enab"},   int'(enab_timer), (m_phase == P_RUN) ? 1 : 0);
    chk({ctx, ".entry"},  int'(entry_active), (m_phase == P_ENTRY) ? 1 : 0);
    chk({ctx, ".done"},   int'(done), (m_phase == P_DONE) ? 1 : 0);
    chk({ctx, ".excl"},   int'(!load_n && enab_timer), 0);
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic cyc(input bit kv, input int kc, input bit st,
                     input bit cn, input bit tz, input string ctx);
    key_valid = kv; key_code = 4'(kc); start_req = st;
    cancel_req = cn; timer_zero = tz;
    @(posedge clk);
    model_edge(kv, kc, st, cn, tz);
    #1;
    check_all(ctx);
  endtask

  task automatic key(input int k, input string ctx);
    cyc(1'b1, k, 1'b0, 1'b0, 1'b0, ctx);
  endtask

  task automatic do_clear(input string ctx);
    key_valid = 0; start_req = 0; cancel_req = 0; timer_zero = 0;
    #2 clear = 1'b1;
    #1;
    m_phase = P_IDLE; m_val = 0; m_cnt = 0;
    check_all(ctx);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    #12;
    check_all("reset");
    @(negedge clk);
    clear = 1'b0;

    // Clear mid-run, then a four-digit entry.
    key(1, "pre");
    cyc(0, 0, 1, 0, 0, "pre_start");
    cyc(0, 0, 0, 0, 0, "pre_run");
    chk("pre_run_enab", int'(enab_timer), 1);
    do_clear("clear_mid_run");
    chk("clear_load_n", int'(load_n), 1);
    key(1, "e1"); key(2, "e2"); key(3, "e3"); key(0, "e4");
    chk("entry_1230", dut_digits(), 16'h1230);
    chk("entry_cnt4", int'(digit_count), 4);

    // Overflow and invalid code.
    cyc(0, 0, 0, 1, 0, "cancel1");
    key(1, "o1"); key(2, "o2"); key(3, "o3"); key(4, "o4"); key(5, "o5");
    chk("ovf_1234", dut_digits(), 16'h1234);
    key(12, "bad_code");
    chk("bad_code_1234", dut_digits(), 16'h1234);

    // Start with normalize 99 -> 00:59.
    cyc(0, 0, 0, 1, 0, "cancel2");
    key(9, "n1"); key(9, "n2");
    cyc(0, 0, 1, 0, 0, "n_start");
    chk("norm_load_n", int'(load_n), 0);
    chk("norm_0059", dut_digits(), 16'h0059);
    cyc(0, 0, 0, 0, 0, "n_run");
    chk("norm_run_enab", int'(enab_timer), 1);
    chk("norm_run_load_n", int'(load_n), 1);
    key(3, "run_key");
    chk("run_key_0059", dut_digits(), 16'h0059);

    // Completion and restart from DONE.
    cyc(0, 0, 0, 0, 1, "tz");
    chk("done_flag", int'(done), 1);
    chk("done_enab", int'(enab_timer), 0);
    key(7, "after_done");
    chk("restart_0007", dut_digits(), 16'h0007);
    chk("restart_cnt", int'(digit_count), 1);
    chk("restart_entry", int'(entry_active), 1);

    // Zero start is ignored.
    cyc(0, 0, 0, 1, 0, "cancel3");
    key(0, "z1");
    cyc(0, 0, 1, 0, 0, "z_start");
    chk("zero_no_load", int'(load_n), 1);
    chk("zero_stay", int'(entry_active), 1);
    key(5, "z2");
    cyc(0, 0, 1, 0, 0, "z_start2");
    chk("zero_then_0005", dut_digits(), 16'h0005);
    chk("zero_then_load", int'(load_n), 0);

    // Cancel in RUN, start beats key, cancel beats start.
    cyc(0, 0, 0, 0, 0, "p_run");
    cyc(0, 0, 0, 1, 0, "cancel_run");
    chk("cancel_run_enab", int'(enab_timer), 0);
    key(4, "p1"); key(2, "p2");
    cyc(1, 8, 1, 0, 0, "start_key");
    chk("start_key_0042", dut_digits(), 16'h0042);
    chk("start_key_load", int'(load_n), 0);
    cyc(0, 0, 0, 1, 0, "cancel4");
    key(6, "c1");
    cyc(0, 0, 1, 1, 0, "cancel_start");
    chk("cancel_start_load", int'(load_n), 1);
    chk("cancel_start_zero", dut_digits(), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_clear("rnd_clear");
      end else begin
        bit kv, st, cn, tz;
        int kc;
        kv = ($urandom_range(0, 99) < 40);
        kc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                         : int'($urandom_range(0, 9));
        st = ($urandom_range(0, 99) < 15);
        cn = ($urandom_range(0, 99) < 3);
        tz = ($urandom_range(0, 99) < 20);
        cyc(kv, kc, st, cn, tz, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
